// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the CoreUART host bridge.
// States, guard-counter width and the overflow counter ceiling live here.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        GUARD
    } state_e;

    localparam int         GUARD_W = 3;
    localparam logic [7:0] OVF_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == OVF_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_bridge_txq.sv
// Synchronous TX byte FIFO for the bridge; instantiated only when UART_BRIDGE_TXQ_EN is defined.
// full/empty come straight from the registered pointers.
module uart_bridge_txq
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_host_bridge.sv
// Stream-to-CoreUART register-port initiator with TX/RX arbitration and post-strobe guard.
// Define UART_BRIDGE_TXQ_EN to replace the single TX holding register with a TXQ_DEPTH FIFO.
module uart_host_bridge
    import uart_bridge_pkg::*;
#(
    parameter int GUARD_CYC = 2,
    parameter int TXQ_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic [1:0] RX_ERR,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       UART_CSN,
    output logic       UART_WEN,
    output logic       UART_OEN,
    output logic [7:0] UART_WDATA,
    input  logic [7:0] UART_RDATA,
    input  logic       UART_TXRDY,
    input  logic       UART_RXRDY,
    input  logic       UART_PARITY_ERR,
    input  logic       UART_FRAMING_ERR,
    input  logic       UART_OVERFLOW,
    output logic [7:0] OVF_COUNT
);

    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYC);

    if (GUARD_CYC < 1 || GUARD_CYC > 7) begin : g_guard_chk
        $error("uart_host_bridge: GUARD_CYC must be in 1..7");
    end
    if (TXQ_DEPTH < 2 || (TXQ_DEPTH & (TXQ_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_host_bridge: TXQ_DEPTH must be a power of 2, at least 2");
    end

    state_e             state_q;
    logic [GUARD_W-1:0] guard_q;
    logic               csn_q, wen_q, oen_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rx_data_q;
    logic [1:0]         rx_err_q;
    logic               rx_valid_q;
    logic               last_was_rd_q;
    logic               ovf_prev_q;
    logic [7:0]         ovf_cnt_q;

    logic       tx_held;
    logic [7:0] tx_head;
    logic       tx_push;
    logic       tx_pop;
    logic       rx_take;
    logic       rd_ok;
    logic       wr_ok;
    logic       pick_rd;
    logic       pick_wr;

    assign tx_push = TX_VALID & TX_READY;
    assign tx_pop  = (state_q == WR);
    assign rx_take = rx_valid_q & RX_READY;
    assign rd_ok   = UART_RXRDY & (~rx_valid_q | RX_READY);
    assign wr_ok   = UART_TXRDY & tx_held;
    // Under contention the previous grant decides, so a pending read never waits behind two writes.
    assign pick_rd = rd_ok & (~wr_ok | ~last_was_rd_q);
    assign pick_wr = wr_ok & ~pick_rd;

`ifdef UART_BRIDGE_TXQ_EN
    logic q_full;
    logic q_empty;
    logic rdy_en_q;

    uart_bridge_txq #(
        .DEPTH (TXQ_DEPTH),
        .W     (8)
    ) u_txq (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (tx_push),
        .wdata_i (TX_DATA),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) rdy_en_q <= 1'b0;
        else       rdy_en_q <= 1'b1;
    end

    assign tx_held  = ~q_empty;
    assign TX_READY = rdy_en_q & ~q_full;
`else
    logic       tx_full_q;
    logic       tx_full_d;
    logic [7:0] tx_hold_q;
    logic       tx_ready_q;

    always_comb begin
        tx_full_d = tx_full_q;
        if (tx_pop)  tx_full_d = 1'b0;
        if (tx_push) tx_full_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_full_q  <= 1'b0;
            tx_hold_q  <= '0;
            tx_ready_q <= 1'b0;
        end else begin
            tx_full_q  <= tx_full_d;
            tx_ready_q <= ~tx_full_d;
            if (tx_push) tx_hold_q <= TX_DATA;
        end
    end

    assign tx_held  = tx_full_q;
    assign tx_head  = tx_hold_q;
    assign TX_READY = tx_ready_q;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            guard_q       <= GUARD_INIT;
            csn_q         <= 1'b1;
            wen_q         <= 1'b1;
            oen_q         <= 1'b1;
            wdata_q       <= '0;
            rx_data_q     <= '0;
            rx_err_q      <= '0;
            rx_valid_q    <= 1'b0;
            last_was_rd_q <= 1'b0;
            ovf_prev_q    <= 1'b0;
            ovf_cnt_q     <= '0;
        end else begin
            ovf_prev_q <= UART_OVERFLOW;
            if (UART_OVERFLOW && !ovf_prev_q) ovf_cnt_q <= sat_inc(ovf_cnt_q);
            if (rx_take) rx_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (guard_q != '0) begin
                        guard_q <= guard_q - GUARD_W'(1);
                    end else if (pick_rd) begin
                        state_q       <= RD;
                        csn_q         <= 1'b0;
                        oen_q         <= 1'b0;
                        last_was_rd_q <= 1'b1;
                    end else if (pick_wr) begin
                        state_q       <= WR;
                        csn_q         <= 1'b0;
                        wen_q         <= 1'b0;
                        wdata_q       <= tx_head;
                        last_was_rd_q <= 1'b0;
                    end
                end
                RD: begin
                    rx_data_q  <= UART_RDATA;
                    rx_err_q   <= {UART_FRAMING_ERR, UART_PARITY_ERR};
                    rx_valid_q <= 1'b1;
                    csn_q      <= 1'b1;
                    oen_q      <= 1'b1;
                    guard_q    <= GUARD_INIT;
                    state_q    <= GUARD;
                end
                WR: begin
                    csn_q   <= 1'b1;
                    wen_q   <= 1'b1;
                    guard_q <= GUARD_INIT;
                    state_q <= GUARD;
                end
                GUARD: begin
                    if (guard_q <= GUARD_W'(1)) begin
                        guard_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        guard_q <= guard_q - GUARD_W'(1);
                    end
                end
                default: begin
                    csn_q   <= 1'b1;
                    wen_q   <= 1'b1;
                    oen_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign UART_CSN   = csn_q;
    assign UART_WEN   = wen_q;
    assign UART_OEN   = oen_q;
    assign UART_WDATA = wdata_q;
    assign RX_DATA    = rx_data_q;
    assign RX_ERR     = rx_err_q;
    assign RX_VALID   = rx_valid_q;
    assign OVF_COUNT  = ovf_cnt_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed self-checking bench for uart_host_bridge (default build; UART_BRIDGE_TXQ_EN selects FIFO expectations).
module tb_uart_host_bridge;

    localparam int GUARD_CYC = 2;
`ifdef UART_BRIDGE_TXQ_EN
    localparam int EXP_ACC = 4;
`else
    localparam int EXP_ACC = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic [1:0] RX_ERR;
    logic       RX_VALID;
    logic       RX_READY;
    logic       UART_CSN, UART_WEN, UART_OEN;
    logic [7:0] UART_WDATA;
    logic [7:0] UART_RDATA;
    logic       UART_TXRDY, UART_RXRDY;
    logic       UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW;
    logic [7:0] OVF_COUNT;

    int checks = 0;
    int errors = 0;

    uart_host_bridge #(
        .GUARD_CYC (GUARD_CYC),
        .TXQ_DEPTH (4)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .TX_DATA          (TX_DATA),
        .TX_VALID         (TX_VALID),
        .TX_READY         (TX_READY),
        .RX_DATA          (RX_DATA),
        .RX_ERR           (RX_ERR),
        .RX_VALID         (RX_VALID),
        .RX_READY         (RX_READY),
        .UART_CSN         (UART_CSN),
        .UART_WEN         (UART_WEN),
        .UART_OEN         (UART_OEN),
        .UART_WDATA       (UART_WDATA),
        .UART_RDATA       (UART_RDATA),
        .UART_TXRDY       (UART_TXRDY),
        .UART_RXRDY       (UART_RXRDY),
        .UART_PARITY_ERR  (UART_PARITY_ERR),
        .UART_FRAMING_ERR (UART_FRAMING_ERR),
        .UART_OVERFLOW    (UART_OVERFLOW),
        .OVF_COUNT        (OVF_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: one strobe type per cycle, and at least GUARD_CYC quiet cycles between strobes.
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;
    bit          have_last = 0;
    int unsigned n_rd = 0;
    int unsigned n_wr = 0;

    always @(negedge CLK) begin
        cyc++;
        if (RESET) begin
            have_last = 0;
        end else if (UART_CSN === 1'b0) begin
            chk("one_strobe", {31'b0, UART_WEN ^ UART_OEN}, 32'd1);
            if (have_last) chk("guard_gap", {31'b0, (cyc - last_cyc - 1) >= GUARD_CYC}, 32'd1);
            have_last = 1;
            last_cyc  = cyc;
            if (UART_OEN === 1'b0) n_rd++;
            else                   n_wr++;
        end
    end

    task automatic wait_strobe(output bit is_rd, output logic [7:0] wd);
        int unsigned n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (UART_CSN !== 1'b0 && n < 40);
        chk("strobe_seen", {31'b0, UART_CSN}, 32'd0);
        is_rd = (UART_OEN === 1'b0);
        wd    = UART_WDATA;
    endtask

    bit          is_rd;
    logic [7:0]  wd;
    int unsigned rd_snap;
    int          acc;
    logic [7:0]  fill [5];

    initial begin
        RESET = 1'b1;
        TX_DATA = '0; TX_VALID = 1'b0; RX_READY = 1'b0;
        UART_RDATA = '0; UART_TXRDY = 1'b0; UART_RXRDY = 1'b0;
        UART_PARITY_ERR = 1'b0; UART_FRAMING_ERR = 1'b0; UART_OVERFLOW = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_csn", {31'b0, UART_CSN}, 32'd1);
        chk("rst_wen", {31'b0, UART_WEN}, 32'd1);
        chk("rst_oen", {31'b0, UART_OEN}, 32'd1);
        chk("rst_wdata", {24'b0, UART_WDATA}, 32'h0);
        chk("rst_tx_ready", {31'b0, TX_READY}, 32'd0);
        chk("rst_rx_valid", {31'b0, RX_VALID}, 32'd0);
        chk("rst_rx_data", {24'b0, RX_DATA}, 32'h0);
        chk("rst_rx_err", {30'b0, RX_ERR}, 32'h0);
        chk("rst_ovf", {24'b0, OVF_COUNT}, 32'h0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("tx_ready_after_rst", {31'b0, TX_READY}, 32'd1);

        // Single TX
        TX_DATA = 8'hA5; TX_VALID = 1'b1; UART_TXRDY = 1'b1;
        @(negedge CLK);
        TX_VALID = 1'b0;
        wait_strobe(is_rd, wd);
        chk("tx_is_write", {31'b0, is_rd}, 32'd0);
        chk("tx_wdata", {24'b0, wd}, 32'hA5);
        chk("tx_ready_in_wr", {31'b0, TX_READY}, 32'd0);
        @(negedge CLK);
        chk("tx_wen_one_cycle", {30'b0, UART_CSN, UART_WEN}, 32'h3);
        chk("tx_ready_freed", {31'b0, TX_READY}, 32'd1);

        // Single RX with back-pressure
        UART_RDATA = 8'h3C; UART_RXRDY = 1'b1; RX_READY = 1'b0;
        wait_strobe(is_rd, wd);
        chk("rx_is_read", {31'b0, is_rd}, 32'd1);
        chk("rx_strobe_count_tx", n_wr, 32'd1);
        @(negedge CLK);
        chk("rx_valid", {31'b0, RX_VALID}, 32'd1);
        chk("rx_data", {24'b0, RX_DATA}, 32'h3C);
        chk("rx_err_clean", {30'b0, RX_ERR}, 32'h0);
        UART_RDATA = 8'h77;
        rd_snap = n_rd;
        repeat (8) @(negedge CLK);
        chk("bp_no_extra_read", n_rd, rd_snap);
        chk("bp_valid_held", {31'b0, RX_VALID}, 32'd1);
        chk("bp_data_held", {24'b0, RX_DATA}, 32'h3C);
        RX_READY = 1'b1;
        @(negedge CLK);
        chk("bp_consumed", {31'b0, RX_VALID}, 32'd0);
        chk("rd_while_emptying", {30'b0, UART_CSN, UART_OEN}, 32'h0);
        RX_READY = 1'b0;
        @(negedge CLK);
        chk("rx2_valid", {31'b0, RX_VALID}, 32'd1);
        chk("rx2_data", {24'b0, RX_DATA}, 32'h77);
        UART_RXRDY = 1'b0;
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;

        // Parity error capture
        UART_RDATA = 8'hC3; UART_PARITY_ERR = 1'b1; UART_RXRDY = 1'b1;
        wait_strobe(is_rd, wd);
        chk("par_is_read", {31'b0, is_rd}, 32'd1);
        @(negedge CLK);
        UART_RXRDY = 1'b0; UART_PARITY_ERR = 1'b0;
        chk("par_data", {24'b0, RX_DATA}, 32'hC3);
        chk("par_err", {30'b0, RX_ERR}, 32'h1);

        // Overflow edge counting and saturation
        UART_OVERFLOW = 1'b1;
        repeat (3) @(negedge CLK);
        UART_OVERFLOW = 1'b0;
        @(negedge CLK);
        chk("ovf_level_once", {24'b0, OVF_COUNT}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            UART_OVERFLOW = 1'b1; @(negedge CLK);
            UART_OVERFLOW = 1'b0; @(negedge CLK);
        end
        chk("ovf_ten", {24'b0, OVF_COUNT}, 32'd10);
        for (int i = 0; i < 290; i++) begin
            UART_OVERFLOW = 1'b1; @(negedge CLK);
            UART_OVERFLOW = 1'b0; @(negedge CLK);
        end
        chk("ovf_saturate", {24'b0, OVF_COUNT}, 32'd255);

        // Reset during a WR strobe (C3 still pending on RX side)
        UART_TXRDY = 1'b0; TX_DATA = 8'h5E; TX_VALID = 1'b1;
        @(negedge CLK);
        TX_VALID = 1'b0; UART_TXRDY = 1'b1;
        wait_strobe(is_rd, wd);
        chk("rstwr_is_write", {31'b0, is_rd}, 32'd0);
        chk("rstwr_wdata", {24'b0, wd}, 32'h5E);
        #2 RESET = 1'b1;
        #1;
        chk("rstwr_strobes_high", {29'b0, UART_CSN, UART_WEN, UART_OEN}, 32'h7);
        @(negedge CLK);
        chk("rstwr_tx_ready", {31'b0, TX_READY}, 32'd0);
        chk("rstwr_rx_valid", {31'b0, RX_VALID}, 32'd0);
        chk("rstwr_ovf", {24'b0, OVF_COUNT}, 32'd0);
        UART_TXRDY = 1'b0;
        RESET = 1'b0;

        // Contention after reset: RD first, then strict alternation
        TX_DATA = 8'h96; TX_VALID = 1'b1; RX_READY = 1'b1; UART_RDATA = 8'h5A;
        repeat (3) @(negedge CLK);
        UART_RXRDY = 1'b1; UART_TXRDY = 1'b1;
        wait_strobe(is_rd, wd);
        chk("cont0_rd", {31'b0, is_rd}, 32'd1);
        wait_strobe(is_rd, wd);
        chk("cont1_wr", {31'b0, is_rd}, 32'd0);
        chk("cont1_wdata", {24'b0, wd}, 32'h96);
        wait_strobe(is_rd, wd);
        chk("cont2_rd", {31'b0, is_rd}, 32'd1);
        wait_strobe(is_rd, wd);
        chk("cont3_wr", {31'b0, is_rd}, 32'd0);
        chk("cont3_wdata", {24'b0, wd}, 32'h96);
        chk("cont_rx_data", {24'b0, RX_DATA}, 32'h5A);
        UART_RXRDY = 1'b0; TX_VALID = 1'b0;
        repeat (12) @(negedge CLK);
        UART_TXRDY = 1'b0;
        repeat (2) @(negedge CLK);

        // Fill with TXRDY low, then drain in order
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h55;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            TX_DATA = fill[i]; TX_VALID = 1'b1;
            if (TX_READY !== 1'b1) break;
            acc++;
            @(negedge CLK);
        end
        TX_VALID = 1'b0;
        chk("fill_accepted", acc, EXP_ACC);
        @(negedge CLK);
        chk("fill_tx_ready_low", {31'b0, TX_READY}, 32'd0);
        UART_TXRDY = 1'b1;
        for (int k = 0; k < EXP_ACC; k++) begin
            wait_strobe(is_rd, wd);
            chk("drain_is_write", {31'b0, is_rd}, 32'd0);
            chk("drain_order", {24'b0, wd}, {24'b0, fill[k]});
        end
        UART_TXRDY = 1'b0;
        repeat (4) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
